// File: rtl/tile_pkg.sv
// Shared types and limits for the tile collision probe.
package tile_pkg;

    // Footprint and read-latency limits; counter widths derive from them.
    localparam int unsigned SprMax   = 4;
    localparam int unsigned RdLatMax = 4;
    localparam int unsigned IdxW     = $clog2(SprMax);
    localparam int unsigned WaitW    = $clog2(RdLatMax);

    // Signed probe coordinate: holds x-1 = -1 up to 2047 + SprMax.
    localparam int unsigned CoordW   = 13;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StSample,
        StDone
    } state_e;

    // Probe order is the declaration order.
    typedef enum logic [1:0] {
        DirLeft,
        DirRight,
        DirUp,
        DirDown
    } dir_e;

    // Index of the last probe on a side: LEFT/RIGHT walk rows, UP/DOWN walk columns.
    function automatic logic [IdxW-1:0] side_last_idx(dir_e dir, int spr_w, int spr_h);
        if (dir == DirLeft || dir == DirRight) begin
            return IdxW'(spr_h - 1);
        end
        return IdxW'(spr_w - 1);
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Tilemap address generation: bounds check plus row-major linear address.
module tile_addr_gen
    import tile_pkg::*;
#(
    parameter int MAP_W  = 2000,
    parameter int MAP_H  = 15,
    parameter int ADDR_W = 15
) (
    input  logic signed [CoordW-1:0] col,
    input  logic signed [CoordW-1:0] row,
    output logic [ADDR_W-1:0]        addr,
    output logic                     in_bounds
);

    int col_i;
    int row_i;
    int lin;

    // Full 32-bit product before reduction so no row/column bits are lost.
    always_comb begin
        col_i     = int'(col);
        row_i     = int'(row);
        in_bounds = (col_i >= 0) && (col_i < MAP_W) && (row_i >= 0) && (row_i < MAP_H);
        lin       = row_i * MAP_W + col_i;
        addr      = in_bounds ? ADDR_W'(lin) : '0;
    end

endmodule

// File: rtl/tile_collision_probe.sv
// Probes the ring of tiles around an object footprint and reports which sides are blocked.
module tile_collision_probe
    import tile_pkg::*;
#(
    parameter int MAP_W     = 2000,
    parameter int MAP_H     = 15,
    parameter int ADDR_W    = 15,
    parameter int TILE_W    = 4,
    parameter int SPR_W     = 1,
    parameter int SPR_H     = 1,
    parameter int RD_LAT    = 1,
    parameter int SOLID_MIN = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [10:0]       x_tile,
    input  logic [3:0]        y_tile,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [TILE_W-1:0] mem_data,
    output logic              left,
    output logic              right,
    output logic              up,
    output logic              down,
    output logic              busy,
    output logic              done
);

    localparam logic signed [CoordW-1:0] OneC  = CoordW'(1);
    localparam logic signed [CoordW-1:0] SprWC = CoordW'(SPR_W);
    localparam logic signed [CoordW-1:0] SprHC = CoordW'(SPR_H);

    state_e                    state_q;
    state_e                    state_adv;
    dir_e                      dir_q;
    dir_e                      dir_adv;
    logic [IdxW-1:0]           idx_q;
    logic [IdxW-1:0]           idx_adv;
    logic [IdxW-1:0]           side_last;
    logic [WaitW-1:0]          wait_q;
    logic [10:0]               x_q;
    logic [3:0]                y_q;
    logic [3:0]                acc_q;
    logic signed [CoordW-1:0]  x_c;
    logic signed [CoordW-1:0]  y_c;
    logic signed [CoordW-1:0]  idx_c;
    logic signed [CoordW-1:0]  probe_col;
    logic signed [CoordW-1:0]  probe_row;
    logic [ADDR_W-1:0]         gen_addr;
    logic                      gen_in_bounds;
    logic                      last_in_side;
    logic                      solid;

    // Current probe cell from the latched position and the (side, index) pointer.
    always_comb begin
        x_c       = $signed({{(CoordW - 11){1'b0}}, x_q});
        y_c       = $signed({{(CoordW - 4){1'b0}}, y_q});
        idx_c     = $signed({{(CoordW - IdxW){1'b0}}, idx_q});
        probe_col = '0;
        probe_row = '0;
        unique case (dir_q)
            DirLeft:  begin probe_col = x_c - OneC;  probe_row = y_c + idx_c; end
            DirRight: begin probe_col = x_c + SprWC; probe_row = y_c + idx_c; end
            DirUp:    begin probe_col = x_c + idx_c; probe_row = y_c - OneC;  end
            DirDown:  begin probe_col = x_c + idx_c; probe_row = y_c + SprHC; end
            default:  begin probe_col = '0;          probe_row = '0;          end
        endcase
    end

    tile_addr_gen #(
        .MAP_W  (MAP_W),
        .MAP_H  (MAP_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .col       (probe_col),
        .row       (probe_row),
        .addr      (gen_addr),
        .in_bounds (gen_in_bounds)
    );

    // Pointer advance shared by out-of-bounds ISSUE and SAMPLE.
    always_comb begin
        side_last    = side_last_idx(dir_q, SPR_W, SPR_H);
        last_in_side = (idx_q == side_last);
        state_adv    = (last_in_side && dir_q == DirDown) ? StDone : StIssue;
        dir_adv      = last_in_side ? dir_e'(2'(dir_q) + 2'd1) : dir_q;
        idx_adv      = last_in_side ? '0 : idx_q + 1'b1;
        solid        = int'(mem_data) >= SOLID_MIN;
    end

    // Read strobe only for in-bounds probes; address parked at zero otherwise.
    always_comb begin
        mem_rd   = (state_q == StIssue) && gen_in_bounds;
        mem_addr = mem_rd ? gen_addr : '0;
    end

    // Probe sequencer; flags are published together only when the pass completes.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            dir_q   <= DirLeft;
            idx_q   <= '0;
            wait_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            left    <= 1'b0;
            right   <= 1'b0;
            up      <= 1'b0;
            down    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        x_q     <= x_tile;
                        y_q     <= y_tile;
                        dir_q   <= DirLeft;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (gen_in_bounds) begin
                        wait_q  <= WaitW'(RD_LAT - 1);
                        state_q <= (RD_LAT > 1) ? StWait : StSample;
                    end else begin
                        // Off-map cells count as solid without a read.
                        acc_q[dir_q] <= 1'b1;
                        dir_q        <= dir_adv;
                        idx_q        <= idx_adv;
                        state_q      <= state_adv;
                    end
                end
                StWait: begin
                    wait_q <= wait_q - 1'b1;
                    if (wait_q <= WaitW'(1)) begin
                        state_q <= StSample;
                    end
                end
                StSample: begin
                    if (solid) begin
                        acc_q[dir_q] <= 1'b1;
                    end
                    dir_q   <= dir_adv;
                    idx_q   <= idx_adv;
                    state_q <= state_adv;
                end
                StDone: begin
                    left    <= acc_q[0];
                    right   <= acc_q[1];
                    up      <= acc_q[2];
                    down    <= acc_q[3];
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_collision_probe.sv
// Bench for tile_collision_probe: three parameterisations sharing one tilemap.
module tb_tile_collision_probe;

    localparam int MAP_W   = 2000;
    localparam int MAP_H   = 15;
    localparam int ADDR_W  = 15;
    localparam int TILE_W  = 4;
    localparam int N       = 3;
    localparam int MAX_CYC = 200;

    logic              clock = 1'b0;
    logic              resetn;
    logic              start    [N];
    logic [10:0]       x_tile   [N];
    logic [3:0]        y_tile   [N];
    logic [ADDR_W-1:0] mem_addr [N];
    logic              mem_rd   [N];
    logic [TILE_W-1:0] mem_data [N];
    logic              left     [N];
    logic              right    [N];
    logic              up       [N];
    logic              down     [N];
    logic              busy     [N];
    logic              done     [N];

    int total    = 0;
    int bad      = 0;
    int addr_bad = 0;

    logic [TILE_W-1:0] mem [MAP_W*MAP_H];
    logic pv [N][4];
    int   pa [N][4];
    int   rdq  [N][$];
    int   expq [N][$];

    always #5 clock = ~clock;

    // dut0: defaults; dut1: 2x3 footprint; dut2: 3-cycle reads, SOLID_MIN 8
    tile_collision_probe u_dut0 (
        .clock(clock), .resetn(resetn), .start(start[0]), .x_tile(x_tile[0]),
        .y_tile(y_tile[0]), .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]),
        .mem_data(mem_data[0]), .left(left[0]), .right(right[0]), .up(up[0]),
        .down(down[0]), .busy(busy[0]), .done(done[0])
    );

    tile_collision_probe #(.SPR_W(2), .SPR_H(3)) u_dut1 (
        .clock(clock), .resetn(resetn), .start(start[1]), .x_tile(x_tile[1]),
        .y_tile(y_tile[1]), .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]),
        .mem_data(mem_data[1]), .left(left[1]), .right(right[1]), .up(up[1]),
        .down(down[1]), .busy(busy[1]), .done(done[1])
    );

    tile_collision_probe #(.RD_LAT(3), .SOLID_MIN(8)) u_dut2 (
        .clock(clock), .resetn(resetn), .start(start[2]), .x_tile(x_tile[2]),
        .y_tile(y_tile[2]), .mem_addr(mem_addr[2]), .mem_rd(mem_rd[2]),
        .mem_data(mem_data[2]), .left(left[2]), .right(right[2]), .up(up[2]),
        .down(down[2]), .busy(busy[2]), .done(done[2])
    );

    function automatic int spr_w_of(int k); return (k == 1) ? 2 : 1; endfunction
    function automatic int spr_h_of(int k); return (k == 1) ? 3 : 1; endfunction
    function automatic int lat_of(int k);   return (k == 2) ? 3 : 1; endfunction
    function automatic int smin_of(int k);  return (k == 2) ? 8 : 1; endfunction

    // Memory model: data valid exactly L cycles after the strobe, all-ones garbage otherwise.
    for (genvar g = 0; g < N; g++) begin : g_mem
        localparam int L = (g == 2) ? 3 : 1;
        assign mem_data[g] = pv[g][L-1] ? mem[pa[g][L-1]] : '1;
    end

    // Read pipeline, read log and idle-address monitor.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < N; k++)
                for (int s = 0; s < 4; s++) pv[k][s] <= 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                for (int s = 3; s > 0; s--) begin
                    pv[k][s] <= pv[k][s-1];
                    pa[k][s] <= pa[k][s-1];
                end
                pv[k][0] <= (mem_rd[k] === 1'b1);
                pa[k][0] <= int'(mem_addr[k]);
                if (mem_rd[k] === 1'b1) rdq[k].push_back(int'(mem_addr[k]));
                if (mem_rd[k] !== 1'b1 && mem_addr[k] !== '0) addr_bad <= addr_bad + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_map();
        for (int i = 0; i < MAP_W * MAP_H; i++) mem[i] = '0;
    endtask

    // Reference: walk the ring around the footprint in side order straight from the map.
    task automatic model(input int k, input int x, input int y,
                         output logic [3:0] fl, output int cyc);
        int sw, sh, n, c, r;
        sw = spr_w_of(k);
        sh = spr_h_of(k);
        expq[k].delete();
        fl  = '0;
        cyc = 1;
        for (int d = 0; d < 4; d++) begin
            n = (d < 2) ? sh : sw;
            for (int i = 0; i < n; i++) begin
                case (d)
                    0:       begin c = x - 1;  r = y + i;  end
                    1:       begin c = x + sw; r = y + i;  end
                    2:       begin c = x + i;  r = y - 1;  end
                    default: begin c = x + i;  r = y + sh; end
                endcase
                if (c < 0 || c >= MAP_W || r < 0 || r >= MAP_H) begin
                    fl[d] = 1'b1;
                    cyc += 1;
                end else begin
                    expq[k].push_back(r * MAP_W + c);
                    if (int'(mem[r * MAP_W + c]) >= smin_of(k)) fl[d] = 1'b1;
                    cyc += lat_of(k) + 1;
                end
            end
        end
    endtask

    // One probe with inputs scrambled while busy; compares against the model.
    task automatic do_probe(input int k, input int x, input int y,
                            output logic [3:0] fl, output int edges);
        logic [3:0] ef;
        int ecyc, cyc, n;
        model(k, x, y, ef, ecyc);
        rdq[k].delete();
        x_tile[k] = 11'(x);
        y_tile[k] = 4'(y);
        start[k]  = 1'b1;
        @(posedge clock); #1;
        cyc = 1;
        check("busy_after_start", busy[k], 1);
        while (done[k] !== 1'b1 && cyc < MAX_CYC) begin
            start[k]  = 1'($urandom);
            x_tile[k] = 11'($urandom);
            y_tile[k] = 4'($urandom);
            @(posedge clock); #1;
            cyc++;
        end
        start[k] = 1'b0;
        check("done_seen", done[k], 1);
        edges = cyc - 1;
        fl = {down[k], up[k], right[k], left[k]};
        check("latency", edges, ecyc);
        check("flag_left", left[k], ef[0]);
        check("flag_right", right[k], ef[1]);
        check("flag_up", up[k], ef[2]);
        check("flag_down", down[k], ef[3]);
        check("busy_at_done", busy[k], 0);
        check("read_count", rdq[k].size(), expq[k].size());
        n = (rdq[k].size() < expq[k].size()) ? rdq[k].size() : expq[k].size();
        for (int i = 0; i < n; i++) check("read_addr", rdq[k][i], expq[k][i]);
        @(posedge clock); #1;
        check("done_single_pulse", done[k], 0);
        check("flags_hold", {down[k], up[k], right[k], left[k]}, fl);
    endtask

    initial begin
        logic [3:0] fl;
        int edges, k, x, y, d1, d2;
        int e037 [4];
        int e039 [10];
        e037 = '{10009, 10011, 8010, 12010};
        e039 = '{8019, 10019, 12019, 8022, 10022, 12022, 6020, 6021, 14020, 14021};

        resetn = 1'b0;
        for (int i = 0; i < N; i++) begin
            start[i]  = 1'b0;
            x_tile[i] = '0;
            y_tile[i] = '0;
        end
        clear_map();
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            check("reset_outputs", {left[i], right[i], up[i], down[i], busy[i], done[i],
                                    mem_rd[i]}, 0);
            check("reset_addr", mem_addr[i], 0);
        end
        resetn = 1'b1;
        @(posedge clock); #1;

        // Single solid tile on the left neighbour
        mem[5 * MAP_W + 9] = 4'd3;
        do_probe(0, 10, 5, fl, edges);
        check("t037_flags", fl, 4'b0001);
        check("t037_edges", edges, 9);
        for (int i = 0; i < 4; i++) check("t037_addr", rdq[0][i], e037[i]);
        mem[5 * MAP_W + 9] = 4'd0;

        // Top-left corner: LEFT and UP are off-map
        do_probe(0, 0, 0, fl, edges);
        check("t038_flags", fl, 4'b0101);
        check("t038_reads", rdq[0].size(), 2);

        // 2x3 footprint, solid cell on the right side
        mem[6 * MAP_W + 22] = 4'd1;
        do_probe(1, 20, 4, fl, edges);
        check("t039_flags", fl, 4'b0010);
        check("t039_reads", rdq[1].size(), 10);
        for (int i = 0; i < 10; i++) check("t039_addr", rdq[1][i], e039[i]);
        mem[6 * MAP_W + 22] = 4'd0;

        // 3-cycle reads, code 7 below SOLID_MIN 8 on all neighbours
        mem[7 * MAP_W + 99]  = 4'd7;
        mem[7 * MAP_W + 101] = 4'd7;
        mem[6 * MAP_W + 100] = 4'd7;
        mem[8 * MAP_W + 100] = 4'd7;
        do_probe(2, 100, 7, fl, edges);
        check("t042_flags_7", fl, 4'b0000);
        check("t040_edges", edges, 17);
        mem[8 * MAP_W + 100] = 4'd8;
        do_probe(2, 100, 7, fl, edges);
        check("t042_flags_8", fl, 4'b1000);
        clear_map();

        // Reset during the third probe
        mem[5 * MAP_W + 9] = 4'd3;
        do_probe(0, 10, 5, fl, edges);
        x_tile[0] = 11'd10;
        y_tile[0] = 4'd5;
        start[0]  = 1'b1;
        @(posedge clock); #1;
        start[0] = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("t041_third_read", mem_rd[0], 1);
        resetn = 1'b0;
        #1;
        check("t041_rst_flags", {left[0], right[0], up[0], down[0]}, 0);
        check("t041_rst_busy", busy[0], 0);
        check("t041_rst_rd", mem_rd[0], 0);
        @(posedge clock); #1;
        resetn = 1'b1;
        clear_map();
        @(posedge clock); #1;
        do_probe(0, 50, 7, fl, edges);
        check("t041_flags", fl, 4'b0000);
        check("t041_edges", edges, 9);

        // Start held high re-triggers every pass
        d1 = -1;
        d2 = -1;
        x_tile[0] = 11'd10;
        y_tile[0] = 4'd5;
        start[0]  = 1'b1;
        for (int c = 1; c <= 60 && d2 < 0; c++) begin
            @(posedge clock); #1;
            if (done[0] === 1'b1) begin
                if (d1 < 0) d1 = c;
                else d2 = c;
            end
        end
        start[0] = 1'b0;
        check("hold_first_done", d1, 10);
        check("hold_period", d2 - d1, 10);
        @(posedge clock); #1;
        check("hold_idle_after", busy[0], 0);

        // Randomised maps and positions, including edges and off-map columns
        for (int t = 0; t < 36; t++) begin
            k = t % N;
            for (int i = 0; i < MAP_W * MAP_H; i++)
                mem[i] = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
            case ($urandom_range(0, 5))
                0:       x = 0;
                1:       x = MAP_W - 1;
                2:       x = MAP_W - spr_w_of(k);
                3:       x = 2047;
                default: x = $urandom_range(1, MAP_W - 2);
            endcase
            y = $urandom_range(0, 15);
            do_probe(k, x, y, fl, edges);
        end

        check("addr_zero_without_rd", addr_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
